// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray-code counter with enable, binary/Gray load and wrap-or-saturate ends.
// Binary and Gray outputs are registered from the same next value, so they never disagree.
module gray_updown_counter #(
  parameter int              WIDTH   = 4,
  parameter bit              WRAP    = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_count,
  output logic [WIDTH-1:0] gray_count,
  output logic             wrapped,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] load_dec;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] next_bin;
  logic             next_wrapped;
  logic             next_sat;
  logic             at_end;
  logic             load_blocks;

  always_comb begin
    load_dec            = '0;
    load_dec[WIDTH-1]   = load_val[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      load_dec[i] = load_dec[i+1] ^ load_val[i];
    end
  end

  assign load_bin    = load_gray ? load_dec : load_val;
  assign at_end      = up ? (bin_count == MAX_VAL) : (bin_count == '0);
  // A freshly loaded end value already blocks the direction currently selected.
  assign load_blocks = up ? (load_bin == MAX_VAL) : (load_bin == '0);

  always_comb begin
    next_bin     = bin_count;
    next_wrapped = 1'b0;
    next_sat     = sat;
    if (load) begin
      next_bin = load_bin;
      next_sat = !WRAP && load_blocks;
    end else if (en) begin
      if (!at_end) begin
        next_bin = up ? (bin_count + ONE) : (bin_count - ONE);
        next_sat = 1'b0;
      end else if (WRAP) begin
        next_bin     = up ? '0 : MAX_VAL;
        next_wrapped = 1'b1;
      end else begin
        next_sat = 1'b1;
      end
    end
    if (WRAP) next_sat = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_count  <= RST_VAL;
      gray_count <= RST_VAL ^ (RST_VAL >> 1);
      wrapped    <= 1'b0;
      sat        <= 1'b0;
    end else begin
      bin_count  <= next_bin;
      gray_count <= next_bin ^ (next_bin >> 1);
      wrapped    <= next_wrapped;
      sat        <= next_sat;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Self-checking bench for gray_updown_counter: four parameterisations driven in lockstep,
// compared every cycle against an arithmetic reference model plus directed expectations.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic       load_gray = 1'b0;
  logic [7:0] load_val = '0;

  logic [3:0] a_bin, a_gray, s_bin, s_gray, r_bin, r_gray;
  logic [7:0] w_bin, w_gray;
  logic       a_wr, a_sat, s_wr, s_sat, r_wr, r_sat, w_wr, w_sat;

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4), .WRAP(1'b1), .RST_VAL(4'd0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(load_val[3:0]), .bin_count(a_bin), .gray_count(a_gray), .wrapped(a_wr), .sat(a_sat));
  gray_updown_counter #(.WIDTH(4), .WRAP(1'b0), .RST_VAL(4'd0)) u_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(load_val[3:0]), .bin_count(s_bin), .gray_count(s_gray), .wrapped(s_wr), .sat(s_sat));
  gray_updown_counter #(.WIDTH(4), .WRAP(1'b1), .RST_VAL(4'd5)) u_r (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(load_val[3:0]), .bin_count(r_bin), .gray_count(r_gray), .wrapped(r_wr), .sat(r_sat));
  gray_updown_counter #(.WIDTH(8), .WRAP(1'b1), .RST_VAL(8'd0)) u_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(load_val), .bin_count(w_bin), .gray_count(w_gray), .wrapped(w_wr), .sat(w_sat));

  // Reference model configuration: index 0=u_a, 1=u_s, 2=u_r, 3=u_w
  int W[4]  = '{4, 4, 4, 8};
  int WR[4] = '{1, 0, 1, 1};
  int RV[4] = '{0, 0, 5, 0};
  int m_bin[4];
  int m_wr[4];
  int m_sat[4];
  int step_ok[4];
  int prev_gray[4];

  int n_assert = 0;
  int n_fail = 0;
  int wrap_seen;

  logic [3:0] gseq[16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                           4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  function automatic int obs_bin(int i);
    case (i)
      0: return int'(a_bin);
      1: return int'(s_bin);
      2: return int'(r_bin);
      default: return int'(w_bin);
    endcase
  endfunction

  function automatic int obs_gray(int i);
    case (i)
      0: return int'(a_gray);
      1: return int'(s_gray);
      2: return int'(r_gray);
      default: return int'(w_gray);
    endcase
  endfunction

  function automatic int obs_wr(int i);
    case (i)
      0: return int'(a_wr);
      1: return int'(s_wr);
      2: return int'(r_wr);
      default: return int'(w_wr);
    endcase
  endfunction

  function automatic int obs_sat(int i);
    case (i)
      0: return int'(a_sat);
      1: return int'(s_sat);
      2: return int'(r_sat);
      default: return int'(w_sat);
    endcase
  endfunction

  // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
  function automatic int gray_to_bin(int g, int w);
    int b = 0;
    for (int k = 0; k < w; k++) begin
      int x = 0;
      for (int j = k; j < w; j++) x = x ^ ((g >> j) & 1);
      b = b | (x << k);
    end
    return b;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int mx = (1 << W[i]) - 1;
      int lv = int'(load_val) & mx;
      step_ok[i] = 0;
      if (rst) begin
        m_bin[i] = RV[i]; m_wr[i] = 0; m_sat[i] = 0;
      end else if (load) begin
        int v = load_gray ? gray_to_bin(lv, W[i]) : lv;
        m_bin[i] = v; m_wr[i] = 0;
        m_sat[i] = (WR[i] == 0 && ((up && v == mx) || (!up && v == 0))) ? 1 : 0;
      end else if (en) begin
        m_wr[i] = 0;
        if (up && m_bin[i] < mx) begin
          m_bin[i]++; m_sat[i] = 0; step_ok[i] = 1;
        end else if (!up && m_bin[i] > 0) begin
          m_bin[i]--; m_sat[i] = 0; step_ok[i] = 1;
        end else if (WR[i] == 1) begin
          m_bin[i] = up ? 0 : mx; m_wr[i] = 1; step_ok[i] = 1;
        end else begin
          m_sat[i] = 1;
        end
      end else begin
        m_wr[i] = 0;
      end
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 4; i++) prev_gray[i] = obs_gray(i);
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bin[%0d]", i), obs_bin(i), m_bin[i]);
      chk($sformatf("gray[%0d]", i), obs_gray(i), m_bin[i] ^ (m_bin[i] >> 1));
      chk($sformatf("wrapped[%0d]", i), obs_wr(i), m_wr[i]);
      chk($sformatf("sat[%0d]", i), obs_sat(i), m_sat[i]);
      if (step_ok[i] == 1)
        chk($sformatf("gray_1bit[%0d]", i), $countones(obs_gray(i) ^ prev_gray[i]), 1);
    end
    if (w_wr) wrap_seen++;
  endtask

  initial begin
    // reset
    rst = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    chk("rst_a_bin", int'(a_bin), 0);
    chk("rst_r_gray", int'(r_gray), 7);
    rst = 1'b0;

    // free-run up through a wrap
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("run_bin", int'(a_bin), i % 16);
      chk("run_gray", int'(a_gray), int'(gseq[i % 16]));
      chk("run_wrapped", int'(a_wr), (i == 16) ? 1 : 0);
    end

    // down-count wrap
    tick();
    chk("dn_pre_bin", int'(a_bin), 1);
    up = 1'b0;
    tick();
    chk("dn_bin0", int'(a_bin), 0);
    chk("dn_wr0", int'(a_wr), 0);
    tick();
    chk("dn_bin15", int'(a_bin), 15);
    chk("dn_gray", int'(a_gray), 4'b1000);
    chk("dn_wr", int'(a_wr), 1);

    // saturation on the WRAP=0 instance
    up = 1'b1; load = 1'b1; load_gray = 1'b0; load_val = 8'd14;
    tick();
    chk("sat_load_bin", int'(s_bin), 14);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_bin", int'(s_bin), 15);
      chk("sat_flag", int'(s_sat), (i == 0) ? 0 : 1);
    end
    up = 1'b0;
    tick();
    chk("sat_rel_bin", int'(s_bin), 14);
    chk("sat_rel_flag", int'(s_sat), 0);

    // Gray load wins over enable
    load = 1'b1; load_gray = 1'b1; load_val = 8'b0000_1101; en = 1'b1;
    tick();
    chk("gld_bin", int'(a_bin), 9);
    chk("gld_gray", int'(a_gray), 4'b1101);
    chk("gld_wr", int'(a_wr), 0);

    // binary load then hold
    load_gray = 1'b0; load_val = 8'd6;
    tick();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_bin", int'(a_bin), 6);
      chk("hold_gray", int'(a_gray), 4'b0101);
    end

    // reset wins over load and enable
    rst = 1'b1; load = 1'b1; en = 1'b1; load_val = 8'd3;
    tick();
    chk("rstmid_bin", int'(r_bin), 5);
    chk("rstmid_gray", int'(r_gray), 4'b0111);
    rst = 1'b0; load = 1'b0; up = 1'b1;

    // 8-bit full cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wrap_seen = 0;
    for (int i = 0; i < 256; i++) tick();
    chk("w8_end_bin", int'(w_bin), 0);
    chk("w8_wrap_count", wrap_seen, 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      load      = ($urandom_range(0, 7) == 0);
      load_gray = 1'($urandom_range(0, 1));
      load_val  = 8'($urandom_range(0, 255));
      en        = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) up = ~up;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_updown_counter.md
# gray_updown_counter

Parametrised up/down Gray-code counter. It is the next-generation replacement for the fixed 4-bit up-only Gray counter. It keeps a binary count and its Gray encoding registered in the same cycle, so both outputs always describe the same count. It adds enable, direction, synchronous load (binary or Gray-encoded), and wrap-or-saturate end behaviour. It serves as the pointer and sequence generator for clock-domain-crossing logic and test pattern sources.

## Interface
- WIDTH, 4: counter width in bits, legal range 2..16.
- WRAP, 1: 1 = wrap at the ends of the range; 0 = saturate at the ends.
- RST_VAL, 0: binary reset value, a WIDTH-bit unsigned integer.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset: synchronous, active-high; clock clk.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load request.
- load_gray  input  1  1 = load_val is Gray-encoded; 0 = load_val is binary.
- load_val  input  WIDTH  value to load.
- bin_count  output  WIDTH  registered binary count.
- gray_count  output  WIDTH  registered Gray code of bin_count.
- wrapped  output  1  one-cycle pulse: the previous step crossed the end of the range.
- sat  output  1  level: the counter is held at a range end (WRAP=0 only).

## Operation
- Priority on each rising edge: rst > load > en > hold.
- rst: bin_count = RST_VAL; gray_count = RST_VAL ^ (RST_VAL >> 1); wrapped = 0; sat = 0.
- load:
  - If load_gray=0, bin_count = load_val.
  - If load_gray=1, bin_count = Gray-to-binary decode of load_val: b[WIDTH-1] = g[WIDTH-1], b[i] = b[i+1] ^ g[i].
  - wrapped = 0.
  - sat = 1 only if WRAP=0 and the loaded value is a range end that would block the current direction (see below); otherwise sat = 0.
  - load overrides en in the same cycle.
- en=1, up=1:
  - If bin_count < 2^WIDTH-1, bin_count increments by 1.
  - At 2^WIDTH-1 with WRAP=1: bin_count = 0 and wrapped pulses.
  - At 2^WIDTH-1 with WRAP=0: bin_count holds and sat = 1.
- en=1, up=0:
  - If bin_count > 0, bin_count decrements by 1.
  - At 0 with WRAP=1: bin_count = 2^WIDTH-1 and wrapped pulses.
  - At 0 with WRAP=0: bin_count holds and sat = 1.
- sat meaning: sat = 1 whenever WRAP=0, en=1, and the requested step was blocked. sat clears on the next edge that performs a successful step, a load of a non-blocking value, or rst. When en=0, sat holds its value.
- en=0 and load=0: all state holds; wrapped = 0.
- gray_count always equals next_bin ^ (next_bin >> 1). It is computed from the value being registered, not from the old bin_count, so there is no one-cycle skew between the two outputs.
- Arithmetic is modulo 2^WIDTH in WIDTH bits; there are no intermediate carries.
- When WRAP=1, sat is tied to 0.
- A direction change takes effect on the first enabled edge after up changes; there is no pipeline.

## Timing
- Latency: one cycle from an input sampled at an edge to the outputs after that edge. All outputs are registered with no combinational input-to-output paths.
- wrapped is high for exactly the cycle following the wrapping edge, then low unless another wrap occurs on the next edge.
- Between any two consecutive enabled steps, gray_count changes in exactly one bit, including across a wrap. A load may change any number of bits.
- Reset mid-count takes effect on the same edge regardless of en, load, or up.
- Single clock domain only. Any crossing of gray_count into another domain is done by the consumer.

## Test plan
- Reset and free-run up: WIDTH=4, WRAP=1, RST_VAL=0, en=1, up=1 for 17 cycles.
  - Required: bin_count 0..15,0; gray_count sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - wrapped high only in the cycle showing bin_count 0 after 15.
  - A checker confirms one Gray bit changes per step.
- Down-count wrap: count reaches 1, then set up=0 for two cycles.
  - Required: bin_count 0, then 15; gray_count 1000; wrapped pulses once.
- Saturation: WRAP=0, load binary 14, en=1, up=1 for three cycles.
  - Required: bin_count 15,15,15; sat 0,1,1.
  - Then set up=0: bin_count 14 and sat 0.
- Gray load: load=1, load_gray=1, load_val=1101 with en=1 in the same cycle.
  - Required: the load wins; bin_count 9; gray_count 1101; wrapped 0.
- Binary load and hold: load_val=6 binary, then en=0 for 5 cycles.
  - Required: bin_count 6 and gray_count 0101 held throughout.
- Reset mid-operation and parameter sweep:
  - Assert rst while load=1 and en=1 with RST_VAL=5. Required: bin_count 5 and gray_count 0111 on the next edge.
  - Repeat the first scenario at WIDTH=8 for 256 steps. Required: the single-bit-change property holds and wrapped is seen exactly once.
